// File: rtl/cpu_mem_pkg.sv
// Shared encodings for the CPU-side memory port: request owner tags,
// access size codes and the grant lock states.
package cpu_mem_pkg;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2
    } size_e;

    typedef enum logic {
        ST_FREE = 1'b0,
        ST_LOCK = 1'b1
    } lock_state_e;

endpackage

// File: rtl/arb_owner_fifo.sv
// In-order FIFO of request owners. Each entry is the master that an accepted
// slave request belongs to. Pointers wrap modulo DEPTH, so DEPTH does not
// have to be a power of two.
module arb_owner_fifo
    import cpu_mem_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          push,
    input  logic          pop,
    input  owner_e        din,
    output owner_e        dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    owner_e          r_mem [DEPTH];
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;
    logic            w_push;
    logic            w_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full   = (r_count == CW'(DEPTH));
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign dout   = r_mem[r_rptr];
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;

    // Storage, pointers and occupancy; push and pop may happen together.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= OWN_INST;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= din;
                r_wptr        <= ptr_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM-like port between the instruction and data requesters.
// The grant is held until the slave accepts, each accepted request's owner
// is queued, and in-order slave responses are routed back to that owner.
module sram_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int unsigned OUTSTANDING = 2,
    parameter bit          DATA_PRIO   = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        slv_req,
    output logic        slv_wr,
    output logic [1:0]  slv_size,
    output logic [3:0]  slv_wstrb,
    output logic [31:0] slv_addr,
    output logic [31:0] slv_wdata,
    input  logic        slv_addr_ok,
    input  logic        slv_data_ok,
    input  logic [31:0] slv_rdata,
    output logic        err_spurious
);

    localparam int unsigned CW = $clog2(OUTSTANDING + 1);

    lock_state_e   r_state;
    lock_state_e   w_state_nxt;
    owner_e        r_lock_own;
    owner_e        w_sel;
    owner_e        w_head;
    logic          w_req_sel;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_resp;
    logic          w_pop;
    logic [CW-1:0] w_count_unused;

    arb_owner_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_owner_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (w_push),
        .pop    (w_pop),
        .din    (w_sel),
        .dout   (w_head),
        .full   (w_full),
        .empty  (w_empty),
        .count  (w_count_unused)
    );

    // Lock state register: remembers the owner of a request still waiting for addr_ok.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= ST_FREE;
            r_lock_own <= OWN_INST;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt == ST_LOCK) begin
                r_lock_own <= w_sel;
            end
        end
    end

    // Next lock state: lock while issued but not accepted; accept or cancel frees it.
    always_comb begin
        w_state_nxt = ST_FREE;
        if (slv_req && !slv_addr_ok) begin
            w_state_nxt = ST_LOCK;
        end
    end

    // Grant owner: locked owner first, otherwise the requester, ties by DATA_PRIO.
    always_comb begin
        w_sel = OWN_INST;
        if (r_state == ST_LOCK) begin
            w_sel = r_lock_own;
        end else if (inst_req && data_req) begin
            w_sel = DATA_PRIO ? OWN_DATA : OWN_INST;
        end else if (data_req) begin
            w_sel = OWN_DATA;
        end
    end

    // Request field mux from the granted owner; instruction fetches are word reads.
    always_comb begin
        slv_wr    = 1'b0;
        slv_size  = SIZE_W;
        slv_wstrb = '0;
        slv_addr  = inst_addr;
        slv_wdata = '0;
        if (w_sel == OWN_DATA) begin
            slv_wr    = data_wr;
            slv_size  = data_size;
            slv_wstrb = data_wstrb;
            slv_addr  = data_addr;
            slv_wdata = data_wdata;
        end
    end

    assign w_req_sel    = (w_sel == OWN_DATA) ? data_req : inst_req;
    assign slv_req      = resetn & w_req_sel & ~w_full;
    assign w_push       = slv_req & slv_addr_ok;
    assign inst_addr_ok = w_push & (w_sel == OWN_INST);
    assign data_addr_ok = w_push & (w_sel == OWN_DATA);

    assign w_resp       = resetn & slv_data_ok;
    assign w_pop        = w_resp & ~w_empty;
    assign inst_data_ok = w_pop & (w_head == OWN_INST);
    assign data_data_ok = w_pop & (w_head == OWN_DATA);
    assign err_spurious = w_resp & w_empty;
    assign inst_rdata   = slv_rdata;
    assign data_rdata   = slv_rdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter (OUTSTANDING=2, DATA_PRIO=1).
// Inputs are driven 1ns after the rising edge, outputs sampled on the falling edge.
module tb_sram_port_arbiter;

    localparam logic [31:0] RD_BASE = 32'hD000_0000;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        slv_req;
    logic        slv_wr;
    logic [1:0]  slv_size;
    logic [3:0]  slv_wstrb;
    logic [31:0] slv_addr;
    logic [31:0] slv_wdata;
    logic        slv_addr_ok;
    logic        slv_data_ok;
    logic [31:0] slv_rdata;
    logic        err_spurious;

    typedef struct {
        logic        own;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   push_cnt = 0;
    int   resp_cnt = 0;

    always #5 clk = ~clk;

    sram_port_arbiter #(
        .OUTSTANDING (2),
        .DATA_PRIO   (1'b1)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .slv_req      (slv_req),
        .slv_wr       (slv_wr),
        .slv_size     (slv_size),
        .slv_wstrb    (slv_wstrb),
        .slv_addr     (slv_addr),
        .slv_wdata    (slv_wdata),
        .slv_addr_ok  (slv_addr_ok),
        .slv_data_ok  (slv_data_ok),
        .slv_rdata    (slv_rdata),
        .err_spurious (err_spurious)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic idle();
        inst_req    = 1'b0;
        inst_addr   = '0;
        data_req    = 1'b0;
        data_wr     = 1'b0;
        data_size   = 2'd0;
        data_wstrb  = '0;
        data_addr   = '0;
        data_wdata  = '0;
        slv_addr_ok = 1'b0;
        slv_data_ok = 1'b0;
        slv_rdata   = '0;
    endtask

    // Slave model: responses carry RD_BASE + response index, in order.
    task automatic give_resp();
        slv_data_ok = 1'b1;
        slv_rdata   = RD_BASE + 32'(resp_cnt);
    endtask

    task automatic expect_accept(input logic own);
        exp_t e;
        e.own   = own;
        e.rdata = RD_BASE + 32'(push_cnt);
        sb_q.push_back(e);
        push_cnt++;
    endtask

    // Compare a slave response cycle against the scoreboard head.
    task automatic resp_check(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            chk({tag, "_spur"}, err_spurious, 1);
            chk({tag, "_idok"}, inst_data_ok, 0);
            chk({tag, "_ddok"}, data_data_ok, 0);
        end else begin
            e = sb_q.pop_front();
            resp_cnt++;
            chk({tag, "_idok"}, inst_data_ok, (e.own == 1'b0) ? 1 : 0);
            chk({tag, "_ddok"}, data_data_ok, (e.own == 1'b1) ? 1 : 0);
            chk({tag, "_irdata"}, inst_rdata, e.rdata);
            chk({tag, "_drdata"}, data_rdata, e.rdata);
            chk({tag, "_spur"}, err_spurious, 0);
        end
    endtask

    initial begin
        idle();
        resetn = 1'b0;

        // Reset: everything held low even with live requests and responses
        tick();
        inst_req    = 1'b1;
        inst_addr   = 32'h1C00_0000;
        slv_addr_ok = 1'b1;
        slv_data_ok = 1'b1;
        at_neg();
        chk("rst_slv_req", slv_req, 0);
        chk("rst_iaok", inst_addr_ok, 0);
        chk("rst_idok", inst_data_ok, 0);
        chk("rst_spur", err_spurious, 0);
        tick();
        idle();
        resetn = 1'b1;
        at_neg();
        chk("idle_slv_req", slv_req, 0);
        chk("idle_spur", err_spurious, 0);

        // 1: inst-only back-to-back
        tick();
        inst_req    = 1'b1;
        inst_addr   = 32'h1C00_0000;
        slv_addr_ok = 1'b1;
        at_neg();
        chk("t1_slv_req", slv_req, 1);
        chk("t1_addr0", slv_addr, 32'h1C00_0000);
        chk("t1_wr", slv_wr, 0);
        chk("t1_size", slv_size, 2);
        chk("t1_iaok0", inst_addr_ok, 1);
        chk("t1_daok0", data_addr_ok, 0);
        expect_accept(1'b0);
        tick();
        inst_addr = 32'h1C00_0004;
        give_resp();
        at_neg();
        resp_check("t1_r0");
        chk("t1_addr1", slv_addr, 32'h1C00_0004);
        chk("t1_iaok1", inst_addr_ok, 1);
        expect_accept(1'b0);
        tick();
        idle();
        give_resp();
        at_neg();
        resp_check("t1_r1");
        tick();
        idle();

        // 2: same-cycle tie, data wins
        inst_req    = 1'b1;
        inst_addr   = 32'h1C00_0008;
        data_req    = 1'b1;
        data_wr     = 1'b0;
        data_size   = 2'd2;
        data_addr   = 32'h0000_1000;
        slv_addr_ok = 1'b1;
        at_neg();
        chk("t2_daok", data_addr_ok, 1);
        chk("t2_iaok0", inst_addr_ok, 0);
        chk("t2_addr0", slv_addr, 32'h0000_1000);
        expect_accept(1'b1);
        tick();
        data_req = 1'b0;
        at_neg();
        chk("t2_iaok1", inst_addr_ok, 1);
        chk("t2_addr1", slv_addr, 32'h1C00_0008);
        expect_accept(1'b0);
        tick();
        idle();
        give_resp();
        at_neg();
        resp_check("t2_r0");
        tick();
        give_resp();
        at_neg();
        resp_check("t2_r1");
        tick();
        idle();

        // 3: inst held by lock for 3 cycles while a data write arrives
        inst_req  = 1'b1;
        inst_addr = 32'h1C00_000C;
        for (int unsigned c = 0; c < 3; c++) begin
            if (c == 1) begin
                data_req   = 1'b1;
                data_wr    = 1'b1;
                data_size  = 2'd2;
                data_wstrb = 4'hF;
                data_addr  = 32'h0000_2000;
                data_wdata = 32'h1234_5678;
            end
            at_neg();
            chk("t3_lk_req", slv_req, 1);
            chk("t3_lk_addr", slv_addr, 32'h1C00_000C);
            chk("t3_lk_iaok", inst_addr_ok, 0);
            chk("t3_lk_daok", data_addr_ok, 0);
            tick();
        end
        slv_addr_ok = 1'b1;
        at_neg();
        chk("t3_acc_addr", slv_addr, 32'h1C00_000C);
        chk("t3_acc_iaok", inst_addr_ok, 1);
        chk("t3_acc_daok", data_addr_ok, 0);
        expect_accept(1'b0);
        tick();
        inst_req = 1'b0;
        at_neg();
        chk("t3_d_addr", slv_addr, 32'h0000_2000);
        chk("t3_d_wr", slv_wr, 1);
        chk("t3_d_wstrb", slv_wstrb, 32'hF);
        chk("t3_d_wdata", slv_wdata, 32'h1234_5678);
        chk("t3_d_daok", data_addr_ok, 1);
        expect_accept(1'b1);
        tick();
        idle();
        give_resp();
        at_neg();
        resp_check("t3_r0");
        tick();
        give_resp();
        at_neg();
        resp_check("t3_r1");
        tick();
        idle();

        // 4: full blocks the third request, even during the pop cycle
        inst_req    = 1'b1;
        inst_addr   = 32'h1C00_0010;
        slv_addr_ok = 1'b1;
        at_neg();
        chk("t4_iaok0", inst_addr_ok, 1);
        expect_accept(1'b0);
        tick();
        inst_addr = 32'h1C00_0014;
        at_neg();
        chk("t4_iaok1", inst_addr_ok, 1);
        expect_accept(1'b0);
        tick();
        inst_req  = 1'b0;
        data_req  = 1'b1;
        data_addr = 32'h0000_3000;
        data_size = 2'd0;
        at_neg();
        chk("t4_full_req", slv_req, 0);
        chk("t4_full_daok", data_addr_ok, 0);
        tick();
        give_resp();
        at_neg();
        resp_check("t4_r0");
        chk("t4_pop_req", slv_req, 0);
        chk("t4_pop_daok", data_addr_ok, 0);
        tick();
        slv_data_ok = 1'b0;
        at_neg();
        chk("t4_resume_req", slv_req, 1);
        chk("t4_resume_daok", data_addr_ok, 1);
        chk("t4_resume_size", slv_size, 0);
        expect_accept(1'b1);
        tick();
        idle();
        give_resp();
        at_neg();
        resp_check("t4_r1");
        tick();
        give_resp();
        at_neg();
        resp_check("t4_r2");
        tick();
        idle();

        // 5: spurious response on an empty FIFO
        give_resp();
        at_neg();
        resp_check("t5");
        tick();
        idle();
        at_neg();
        chk("t5_after_spur", err_spurious, 0);
        tick();

        // 6: reset with two outstanding
        inst_req    = 1'b1;
        inst_addr   = 32'h1C00_0020;
        slv_addr_ok = 1'b1;
        at_neg();
        expect_accept(1'b0);
        tick();
        inst_addr = 32'h1C00_0024;
        at_neg();
        expect_accept(1'b0);
        tick();
        resetn = 1'b0;
        give_resp();
        at_neg();
        chk("t6_rst_req", slv_req, 0);
        chk("t6_rst_iaok", inst_addr_ok, 0);
        chk("t6_rst_idok", inst_data_ok, 0);
        chk("t6_rst_spur", err_spurious, 0);
        sb_q.delete();
        resp_cnt = push_cnt;
        tick();
        resetn = 1'b1;
        idle();
        give_resp();
        at_neg();
        resp_check("t6_spur");
        tick();
        idle();
        inst_req    = 1'b1;
        inst_addr   = 32'h1C00_0028;
        slv_addr_ok = 1'b1;
        at_neg();
        chk("t6_post_iaok0", inst_addr_ok, 1);
        expect_accept(1'b0);
        tick();
        inst_addr = 32'h1C00_002C;
        at_neg();
        chk("t6_post_iaok1", inst_addr_ok, 1);
        expect_accept(1'b0);
        tick();
        idle();
        give_resp();
        at_neg();
        resp_check("t6_r0");
        tick();
        give_resp();
        at_neg();
        resp_check("t6_r1");
        tick();
        idle();
        at_neg();
        chk("end_sb_empty", 32'(sb_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
